// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter:
//   - arb_state_t      : arbiter FSM state encoding (IDLE / ACCESS / RESP)
//   - MAS_* constants  : RAM access size codes (byte / half / word / undefined)
//   - DIR_RD / DIR_WR  : RAM direction codes (1 = read, 0 = write)
//   - is_misaligned()  : size/address alignment rule, used by the top level
//                        only when MEM_ARB_ALIGN_CHECK_EN is defined
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic [1:0] MAS_BYTE  = 2'b00;
    localparam logic [1:0] MAS_HALF  = 2'b01;
    localparam logic [1:0] MAS_WORD  = 2'b10;
    localparam logic [1:0] MAS_UNDEF = 2'b11;

    localparam logic DIR_RD = 1'b1;
    localparam logic DIR_WR = 1'b0;

    // True when an access of size 'mas' cannot start at byte lane 'lane'.
    // The undefined size code is always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] mas,
                                           input logic [1:0] lane);
        logic bad;
        case (mas)
            MAS_BYTE: bad = 1'b0;
            MAS_HALF: bad = lane[0];
            MAS_WORD: bad = (lane != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr
// Two-way round-robin selector between the fetch port and the data port.
// Ports:
//   if_req    in  1  fetch port is requesting
//   d_req     in  1  data port is requesting
//   last_data in  1  previous grant went to the data port (0 = fetch)
//   gnt_data  out 1  1 = grant data port, 0 = grant fetch port
// Only meaningful when at least one request is asserted.
// -----------------------------------------------------------------------------
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_data,
    output logic gnt_data
);

    always_comb begin
        if (if_req && d_req) begin
            // Tie: the port that was not served last time wins.
            gnt_data = ~last_data;
        end else begin
            gnt_data = d_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port (word reads only) and a data port
// (byte/half/word reads and writes) onto a single RAM port.
//
// Parameters:
//   ADDR_W   byte-address width of both requester ports and the RAM port
//   DATA_W   width of all data buses
//   WAIT_MAX ACCESS cycles allowed before the access is faulted
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   if_req, if_addr            fetch request and byte address
//   if_ack, if_rdata           fetch completion pulse and read data
//   d_req, d_rw, d_mas         data request, direction (1 = read), size
//   d_addr, d_wdata            data byte address and write data
//   d_ack, d_rdata, d_fault    data completion pulse, read data, error flag
//   ram_en, ram_rw, ram_mas    RAM enable, direction, size
//   ram_a, ram_addr, ram_din   RAM byte lane, word-aligned address, write data
//   ram_dout, ram_done         RAM read data and completion
//   dbg_state                  current FSM state (arb_state_t encoding)
//
// Handshake: a requester raises req with stable fields and holds them until
// its ack pulse. The fields are captured at the grant edge, so a req that
// drops mid-access does not cancel it. A req still high during the ack cycle
// is arbitrated again in the following IDLE cycle; every access is separated
// from the next by at least one IDLE cycle.
//
// Configuration macro: MEM_ARB_ALIGN_CHECK_EN
//   defined   : misaligned data requests (or size 11) skip the RAM and complete
//               with d_fault = 1 in the cycle after the grant.
//   undefined : no alignment check; size 11 is forwarded as word and the
//               address is forwarded unchanged.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_mas,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_fault,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [1:0]        ram_mas,
    output logic [1:0]        ram_a,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_done,
    output logic [1:0]        dbg_state
);

    // Counter only has to reach WAIT_MAX-1 (the last ACCESS cycle index).
    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

    arb_state_t        state_q, state_d;
    logic              last_data_q, last_data_d;  // 0 = last grant was fetch
    logic              gnt_data_q, gnt_data_d;    // owner of current access
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [1:0]        mas_q, mas_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic any_req;
    logic rr_gnt_data;
    logic d_misalign;
    logic timeout;
    logic [1:0] d_mas_fwd;

    mem_arb_rr u_rr (
        .if_req    (if_req),
        .d_req     (d_req),
        .last_data (last_data_q),
        .gnt_data  (rr_gnt_data)
    );

    assign any_req = if_req | d_req;
    assign timeout = (cnt_q == CNT_W'(WAIT_MAX - 1));
    // The undefined size code never reaches the RAM as-is.
    assign d_mas_fwd = (d_mas == MAS_UNDEF) ? MAS_WORD : d_mas;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign d_misalign = is_misaligned(d_mas, d_addr[1:0]);
`else
    assign d_misalign = 1'b0;
`endif

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    // A rejected data request completes without touching RAM.
                    state_d = (rr_gnt_data && d_misalign) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ram_done || timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_data_q <= 1'b0;
            gnt_data_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            mas_q       <= 2'b00;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            last_data_q <= last_data_d;
            gnt_data_q  <= gnt_data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            mas_q       <= mas_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        last_data_d = last_data_q;
        gnt_data_d  = gnt_data_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        mas_d       = mas_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;

        if (state_q == ST_IDLE && any_req) begin
            // Grant edge: capture the winner's request fields.
            last_data_d = rr_gnt_data;
            gnt_data_d  = rr_gnt_data;
            rdata_d     = '0;
            cnt_d       = '0;
            if (rr_gnt_data) begin
                addr_d  = d_addr;
                wdata_d = d_wdata;
                rw_d    = d_rw;
                mas_d   = d_mas_fwd;
                fault_d = d_misalign;
            end else begin
                addr_d  = if_addr;
                wdata_d = '0;
                rw_d    = DIR_RD;
                mas_d   = MAS_WORD;
                fault_d = 1'b0;
            end
        end else if (state_q == ST_ACCESS) begin
            // ram_done wins over a timeout landing in the same cycle.
            if (ram_done) begin
                if (rw_q == DIR_RD) begin
                    rdata_d = ram_dout;
                end
            end else if (timeout) begin
                fault_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ----------------------------------------------------------------- outputs
    always_comb begin
        ram_en    = (state_q == ST_ACCESS);
        ram_rw    = rw_q;
        ram_mas   = mas_q;
        ram_a     = addr_q[1:0];
        ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        ram_din   = wdata_q;
        if_ack    = (state_q == ST_RESP) && !gnt_data_q;
        d_ack     = (state_q == ST_RESP) &&  gnt_data_q;
        if_rdata  = if_ack ? rdata_q : '0;
        d_rdata   = d_ack  ? rdata_q : '0;
        d_fault   = d_ack  && fault_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the rising
// edge that updates the design. The RAM side is either driven by hand
// (ram_auto = 0) or by a responder that completes in the first ACCESS cycle
// and returns 0xA5000000 | ram_addr (ram_auto = 1).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 32;
    localparam int WAIT_MAX = 15;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_rw;
    logic [1:0]        d_mas;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_fault;
    logic              ram_en;
    logic              ram_rw;
    logic [1:0]        ram_mas;
    logic [1:0]        ram_a;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_done;
    logic [1:0]        dbg_state;

    logic              ram_auto;
    logic              ram_done_drv;
    logic [DATA_W-1:0] ram_dout_drv;

    int n_vec;
    int n_err;

    assign ram_done = ram_auto ? ram_en : ram_done_drv;
    assign ram_dout = ram_auto ? (32'hA500_0000 | {23'd0, ram_addr}) : ram_dout_drv;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_rw      (d_rw),
        .d_mas     (d_mas),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_fault   (d_fault),
        .ram_en    (ram_en),
        .ram_rw    (ram_rw),
        .ram_mas   (ram_mas),
        .ram_a     (ram_a),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_done  (ram_done),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        n_vec++; if (ram_en !== 1'b0) begin n_err++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
        n_vec++; if ({if_ack, d_ack, d_fault} !== 3'b000) begin n_err++; $display("FAIL rst_acks: got %b want 000", {if_ack, d_ack, d_fault}); end
        n_vec++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
        n_vec++; if (ram_addr !== 9'd0 || ram_din !== 32'd0) begin n_err++; $display("FAIL rst_ram_bus: got %h/%h want 0/0", ram_addr, ram_din); end
        n_vec++; if ({ram_mas, ram_a, ram_rw} !== 5'd0) begin n_err++; $display("FAIL rst_ram_ctl: got %b want 00000", {ram_mas, ram_a, ram_rw}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_basic();
        ram_auto = 1'b0; ram_done_drv = 1'b0; ram_dout_drv = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 9'h010;
        @(negedge clk);  // grant edge has passed -> ACCESS
        n_vec++; if (ram_en !== 1'b1) begin n_err++; $display("FAIL fetch_ram_en: got %b want 1", ram_en); end
        n_vec++; if (ram_addr !== 9'h010 || ram_mas !== 2'b10 || ram_rw !== 1'b1) begin n_err++;
            $display("FAIL fetch_ram_ctl: got addr=%h mas=%b rw=%b want addr=010 mas=10 rw=1", ram_addr, ram_mas, ram_rw); end
        n_vec++; if (if_ack !== 1'b0) begin n_err++; $display("FAIL fetch_early_ack: got %b want 0", if_ack); end
        ram_done_drv = 1'b1;
        @(negedge clk);  // grant + 2
        n_vec++; if (if_ack !== 1'b1 || d_ack !== 1'b0) begin n_err++; $display("FAIL fetch_ack: got if=%b d=%b want if=1 d=0", if_ack, d_ack); end
        n_vec++; if (if_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); end
        n_vec++; if (ram_en !== 1'b0) begin n_err++; $display("FAIL fetch_resp_ram_en: got %b want 0", ram_en); end
        if_req = 1'b0; ram_done_drv = 1'b0;
        @(negedge clk);
        n_vec++; if (if_ack !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL fetch_pulse: got ack=%b state=%0d want ack=0 state=0", if_ack, dbg_state); end
    endtask

    // Both ports held high: expect data, fetch, data, each ack 3 cycles apart.
    task automatic test_round_robin();
        logic [2:0] exp_data;
        int  cyc, n_ack, last_cyc;
        logic was_ack;
        exp_data = 3'b101;  // bit i = 1 means ack #i goes to data
        ram_auto = 1'b1;
        if_req = 1'b1; if_addr = 9'h040;
        d_req = 1'b1; d_rw = 1'b1; d_mas = 2'b10; d_addr = 9'h020; d_wdata = 32'h0;
        cyc = 0; n_ack = 0; last_cyc = 0; was_ack = 1'b0;
        while (n_ack < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (was_ack) begin
                n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rr_idle_gap: got state %0d want 0", dbg_state); end
            end
            was_ack = if_ack | d_ack;
            if (if_ack | d_ack) begin
                n_vec++; if (d_ack !== exp_data[n_ack] || if_ack !== !exp_data[n_ack]) begin n_err++;
                    $display("FAIL rr_order%0d: got d=%b if=%b want d=%b", n_ack, d_ack, if_ack, exp_data[n_ack]); end
                if (d_ack) begin
                    n_vec++; if (d_rdata !== 32'hA500_0020) begin n_err++; $display("FAIL rr_d_rdata: got %h want a5000020", d_rdata); end
                end else begin
                    n_vec++; if (if_rdata !== 32'hA500_0040) begin n_err++; $display("FAIL rr_if_rdata: got %h want a5000040", if_rdata); end
                end
                if (n_ack > 0) begin
                    n_vec++; if (cyc - last_cyc !== 3) begin n_err++; $display("FAIL rr_spacing: got %0d want 3", cyc - last_cyc); end
                end
                last_cyc = cyc;
                n_ack++;
            end
        end
        n_vec++; if (n_ack !== 3) begin n_err++; $display("FAIL rr_ack_count: got %0d want 3", n_ack); end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rr_final_idle: got %0d want 0", dbg_state); end
        @(negedge clk);
        ram_auto = 1'b0;
    endtask

    task automatic test_half_write();
        ram_auto = 1'b0; ram_done_drv = 1'b0; ram_dout_drv = 32'hFFFF_FFFF;
        d_req = 1'b1; d_rw = 1'b0; d_mas = 2'b01; d_addr = 9'h006; d_wdata = 32'h0000_1234;
        @(negedge clk);
        n_vec++; if (ram_en !== 1'b1 || ram_rw !== 1'b0) begin n_err++; $display("FAIL hw_en_rw: got en=%b rw=%b want en=1 rw=0", ram_en, ram_rw); end
        n_vec++; if (ram_mas !== 2'b01 || ram_a !== 2'b10) begin n_err++; $display("FAIL hw_mas_a: got mas=%b a=%b want mas=01 a=10", ram_mas, ram_a); end
        n_vec++; if (ram_addr !== 9'h004 || ram_din !== 32'h0000_1234) begin n_err++; $display("FAIL hw_addr_din: got %h/%h want 004/00001234", ram_addr, ram_din); end
        ram_done_drv = 1'b1;
        @(negedge clk);
        n_vec++; if (d_ack !== 1'b1 || d_fault !== 1'b0) begin n_err++; $display("FAIL hw_ack: got ack=%b fault=%b want ack=1 fault=0", d_ack, d_fault); end
        n_vec++; if (d_rdata !== 32'd0) begin n_err++; $display("FAIL hw_rdata: got %h want 0", d_rdata); end
        d_req = 1'b0; ram_done_drv = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int access_cyc, cyc;
        logic got_ack;
        ram_auto = 1'b0; ram_done_drv = 1'b0; ram_dout_drv = 32'h5555_AAAA;
        d_req = 1'b1; d_rw = 1'b1; d_mas = 2'b10; d_addr = 9'h008;
        access_cyc = 0; cyc = 0; got_ack = 1'b0;
        while (!got_ack && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ram_en) access_cyc++;
            if (d_ack) begin
                got_ack = 1'b1;
                n_vec++; if (d_fault !== 1'b1) begin n_err++; $display("FAIL to_fault: got %b want 1", d_fault); end
                n_vec++; if (d_rdata !== 32'd0) begin n_err++; $display("FAIL to_rdata: got %h want 0", d_rdata); end
            end
        end
        n_vec++; if (got_ack !== 1'b1) begin n_err++; $display("FAIL to_no_ack: got %b want 1", got_ack); end
        n_vec++; if (access_cyc !== WAIT_MAX) begin n_err++; $display("FAIL to_access_cycles: got %0d want %0d", access_cyc, WAIT_MAX); end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_align();
        ram_auto = 1'b0; ram_done_drv = 1'b0; ram_dout_drv = 32'h1357_9BDF;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        d_req = 1'b1; d_rw = 1'b1; d_mas = 2'b10; d_addr = 9'h003;
        @(negedge clk);  // grant + 1
        n_vec++; if (d_ack !== 1'b1 || d_fault !== 1'b1) begin n_err++; $display("FAIL al_word_fault: got ack=%b fault=%b want 1/1", d_ack, d_fault); end
        n_vec++; if (ram_en !== 1'b0 || d_rdata !== 32'd0) begin n_err++; $display("FAIL al_word_ram: got en=%b rdata=%h want 0/0", ram_en, d_rdata); end
        d_mas = 2'b01; d_addr = 9'h005;  // held req: next IDLE grants a misaligned half
        @(negedge clk);
        n_vec++; if (ram_en !== 1'b0 || d_ack !== 1'b0) begin n_err++; $display("FAIL al_idle: got en=%b ack=%b want 0/0", ram_en, d_ack); end
        @(negedge clk);
        n_vec++; if (d_ack !== 1'b1 || d_fault !== 1'b1 || ram_en !== 1'b0) begin n_err++;
            $display("FAIL al_half_fault: got ack=%b fault=%b en=%b want 1/1/0", d_ack, d_fault, ram_en); end
        d_req = 1'b0;
        @(negedge clk);
`else
        d_req = 1'b1; d_rw = 1'b1; d_mas = 2'b11; d_addr = 9'h003;
        @(negedge clk);
        n_vec++; if (ram_en !== 1'b1 || ram_mas !== 2'b10) begin n_err++; $display("FAIL al_fwd_mas: got en=%b mas=%b want 1/10", ram_en, ram_mas); end
        n_vec++; if (ram_a !== 2'b11 || ram_addr !== 9'h000) begin n_err++; $display("FAIL al_fwd_addr: got a=%b addr=%h want 11/000", ram_a, ram_addr); end
        ram_done_drv = 1'b1;
        @(negedge clk);
        n_vec++; if (d_ack !== 1'b1 || d_fault !== 1'b0 || d_rdata !== 32'h1357_9BDF) begin n_err++;
            $display("FAIL al_fwd_ack: got ack=%b fault=%b rdata=%h want 1/0/13579bdf", d_ack, d_fault, d_rdata); end
        d_req = 1'b0; ram_done_drv = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_access();
        logic spurious;
        ram_auto = 1'b0; ram_done_drv = 1'b0; ram_dout_drv = 32'hFEED_FACE;
        if_req = 1'b1; if_addr = 9'h100;
        @(negedge clk);
        n_vec++; if (ram_en !== 1'b1) begin n_err++; $display("FAIL rm_access: got %b want 1", ram_en); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (ram_en !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL rm_async: got en=%b state=%0d want 0/0", ram_en, dbg_state); end
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        spurious = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if_ack || d_ack || ram_en) spurious = 1'b1;
        end
        n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL rm_no_ack: got %b want 0", spurious); end
        // Normal service afterwards.
        ram_dout_drv = 32'h0BAD_F00D;
        if_req = 1'b1; if_addr = 9'h01C;
        @(negedge clk);
        n_vec++; if (ram_en !== 1'b1 || ram_addr !== 9'h01C) begin n_err++; $display("FAIL rm_next_access: got en=%b addr=%h want 1/01c", ram_en, ram_addr); end
        ram_done_drv = 1'b1;
        @(negedge clk);
        n_vec++; if (if_ack !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rm_next_ack: got ack=%b rdata=%h want 1/0badf00d", if_ack, if_rdata); end
        if_req = 1'b0; ram_done_drv = 1'b0;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------- main
    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_rw = 1'b0; d_mas = 2'b00; d_addr = '0; d_wdata = '0;
        ram_auto = 1'b0; ram_done_drv = 1'b0; ram_dout_drv = '0;

        test_reset();
        test_fetch_basic();
        test_round_robin();
        test_half_write();
        test_timeout();
        test_align();
        test_reset_mid_access();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width of both requester ports and the RAM port.
REQ-002 Parameter DATA_W, default 32, data width of all data buses.
REQ-003 Parameter WAIT_MAX, default 15, maximum ACCESS cycles allowed before a timeout fault.
REQ-004 Clocking SHALL be a single clock; reset SHALL be asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 if_req  in  1  instruction-fetch request; the fetch port issues word reads only.
REQ-008 if_addr  in  ADDR_W  fetch byte address.
REQ-009 if_ack  out  1  one-cycle pulse when the fetch access completes.
REQ-010 if_rdata  out  DATA_W  fetch read data; valid only while if_ack=1.
REQ-011 d_req, d_rw, d_mas  in  1,1,2  data request; d_rw: 1=read, 0=write; d_mas: 00=byte, 01=half, 10=word, 11=undefined.
REQ-012 d_addr, d_wdata  in  ADDR_W, DATA_W  data byte address and write data.
REQ-013 d_ack, d_rdata, d_fault  out  1, DATA_W, 1  completion pulse, read data, and error flag; d_rdata and d_fault are valid only with d_ack.
REQ-014 ram_en, ram_rw, ram_mas, ram_a  out  1,1,2,2  RAM enable, direction, size and byte lane.
REQ-015 ram_addr, ram_din  out  ADDR_W, DATA_W  RAM word-aligned address and write data.
REQ-016 ram_dout, ram_done  in  DATA_W, 1  RAM read data and completion.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-018 In IDLE, a pending request SHALL be granted at the clock edge and the FSM SHALL move to ACCESS.
REQ-019 Requester fields SHALL be latched at grant, and RAM outputs SHALL be driven only from these latched values.
REQ-020 When if_req and d_req are sampled together, the port not granted last SHALL win (round-robin); the last-grant bit SHALL reset to "fetch", so data wins the first tie.
REQ-021 ram_addr SHALL be {addr[ADDR_W-1:2],2'b00}.
REQ-022 ram_a SHALL be addr[1:0].
REQ-023 For fetch, ram_mas=10 and ram_rw=1.
REQ-024 ram_en SHALL be 1 only in ACCESS.
REQ-025 In ACCESS, sampling ram_done=1 SHALL capture ram_dout (reads) and move the FSM to RESP.
REQ-026 ACCESS SHALL count cycles; if the count reaches WAIT_MAX without ram_done, the FSM SHALL move to RESP with fault set.
REQ-027 In RESP, the granted port's ack SHALL pulse for exactly one cycle with its rdata/fault, and the FSM SHALL then return to IDLE.
REQ-028 Minimum latency SHALL be 2 cycles: ack is high in the second cycle after the grant edge.
REQ-029 Write accesses SHALL return d_rdata=0.
REQ-030 A fetch timeout SHALL return if_rdata=0 and pulse if_ack; fetch has no fault output.
REQ-031 A requester SHALL hold req and its fields until ack; deasserting req mid-access SHALL NOT abort the access, and ack still pulses.
REQ-032 A request still asserted in the ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-033 No back-to-back grants: at least one IDLE cycle SHALL separate accesses.

Reset
REQ-034 Reset SHALL force, immediately: state=IDLE, last-grant=fetch, counter=0.
REQ-035 Reset SHALL force ram_en, if_ack, d_ack and d_fault to 0 and if_rdata, d_rdata, ram_addr, ram_din, ram_mas, ram_a, ram_rw to 0.
REQ-036 Reset asserted mid-access SHALL abandon the access with no ack.

Configuration
REQ-037 Macro MEM_ARB_ALIGN_CHECK_EN defined: data requests with d_mas=11, half with d_addr[0]=1, or word with d_addr[1:0]!=00 SHALL skip ACCESS, go IDLE->RESP, and pulse d_ack with d_fault=1 and d_rdata=0; ram_en SHALL stay 0.
REQ-038 Macro not defined: no alignment check; d_mas=11 SHALL be forwarded as 10, and misaligned addresses SHALL be forwarded unchanged.

Structure
REQ-039 Package mem_arb_pkg SHALL hold the state enumeration, the MAS constants (MAS_BYTE, MAS_HALF, MAS_WORD) and the RD/WR direction constants.
REQ-040 Round-robin selection SHALL be a sub-module, mem_arb_rr (inputs: two requests and last-grant; output: grant select).

Verification
REQ-041 Bench SHALL check: fetch 0x010 with ram_done the next cycle, RAM holding 0xDEADBEEF -> if_ack in grant+2 and if_rdata=0xDEADBEEF.
REQ-042 Bench SHALL check: if_req and d_req together, repeated three times -> grants in order data, fetch, data.
REQ-043 Bench SHALL check: data half write, addr 0x006, wdata 0x1234 -> ram_mas=01, ram_a=10, ram_addr=0x004, d_ack with d_fault=0.
REQ-044 Bench SHALL check: ram_done held low -> d_ack with d_fault=1 after WAIT_MAX=15 ACCESS cycles.
REQ-045 Bench SHALL check, with MEM_ARB_ALIGN_CHECK_EN: word read at 0x003 -> ram_en never 1, d_fault=1 in grant+1.
REQ-046 Bench SHALL check: reset pulsed during ACCESS -> ram_en=0 immediately, no ack, next request is served normally.
